// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-requester arbiter in front of the single data bus port.
// m0 is the core data port, m1 the secondary master (DMA / debug loader).
// One single-word transaction every three cycles: IDLE -> ACCESS -> RESP.
// Optional feature: define DBUS_ARB_RR_EN for round-robin tie-breaking;
// without it m0 wins every tie. An active lock overrides either policy.
module dbus_arbiter #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_din,
    output logic          bus_we,
    input  logic [DW-1:0] bus_dout,
    output logic          owner
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e        state;
    logic          lock_hold;
    logic          cur_we;      // direction of the transaction in flight
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;
    logic          owner_lock;
    logic          grant_valid;
    logic          winner;
`ifdef DBUS_ARB_RR_EN
    logic          rr_ptr;      // preferred requester on the next tie
`endif

    assign owner_lock = owner ? m1_lock : m0_lock;

    // Pick the requester granted in IDLE this cycle
    always_comb begin
        grant_valid = 1'b0;
        winner      = 1'b0;
        if (lock_hold && owner_lock) begin
            // Locked: only the current owner may be granted
            winner      = owner;
            grant_valid = owner ? m1_req : m0_req;
        end else if (m0_req && m1_req) begin
            grant_valid = 1'b1;
`ifdef DBUS_ARB_RR_EN
            winner      = rr_ptr;
`else
            winner      = 1'b0;
`endif
        end else if (m0_req) begin
            grant_valid = 1'b1;
            winner      = 1'b0;
        end else if (m1_req) begin
            grant_valid = 1'b1;
            winner      = 1'b1;
        end
    end

    // Transaction FSM with registered bus, ack and read-data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_din    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            owner      <= 1'b0;
            lock_hold  <= 1'b0;
            cur_we     <= 1'b0;
`ifdef DBUS_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    bus_we <= 1'b0;
                    if (lock_hold && !owner_lock) begin
                        lock_hold <= 1'b0;
                    end
                    if (grant_valid) begin
                        bus_we   <= winner ? m1_we    : m0_we;
                        bus_addr <= winner ? m1_addr  : m0_addr;
                        bus_din  <= winner ? m1_wdata : m0_wdata;
                        cur_we   <= winner ? m1_we    : m0_we;
                        owner    <= winner;
`ifdef DBUS_ARB_RR_EN
                        rr_ptr   <= ~winner;
`endif
                        state    <= StAccess;
                    end
                end
                StAccess: begin
                    bus_we <= 1'b0;
                    m0_ack <= ~owner;
                    m1_ack <= owner;
                    state  <= StResp;
                end
                StResp: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (owner_lock) begin
                        lock_hold <= 1'b1;
                    end
                    if (!cur_we) begin
                        if (owner) m1_rdata_q <= bus_dout;
                        else       m0_rdata_q <= bus_dout;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Bus read data is only available in RESP, so forward it during the ack
    // cycle; the captured copy holds it afterwards and across writes.
    always_comb begin
        m0_rdata = m0_rdata_q;
        m1_rdata = m1_rdata_q;
        if (state == StResp && !cur_we) begin
            if (owner) m1_rdata = bus_dout;
            else       m0_rdata = bus_dout;
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: table-driven single transactions, contention,
// lock and mid-transaction reset sequences, checked through per-requester
// scoreboards against a small RAM/GPIO bus model.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [15:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_ack, m1_ack, bus_we, owner;
    logic [15:0] m0_rdata, m1_rdata, bus_addr, bus_din;
    logic [15:0] bus_dout = 0;

    dbus_arbiter #(.DW(16), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_we(bus_we),
        .bus_dout(bus_dout), .owner(owner)
    );

    always #5 clk = ~clk;

    // Data bus model: RAM below 0x2000, GPIO in at 0x2000, GPIO out at 0x2001
    logic [15:0] mem [256];
    logic [15:0] gpio_out = 0;
    logic [15:0] gpio_in = 16'h001A;
    always @(posedge clk) begin
        if (bus_we) begin
            if (bus_addr == 16'h2001) gpio_out <= bus_din;
            else if (bus_addr < 16'h2000) mem[bus_addr[7:0]] <= bus_din;
        end
        if (bus_addr == 16'h2000)      bus_dout <= gpio_in;
        else if (bus_addr == 16'h2001) bus_dout <= gpio_out;
        else                           bus_dout <= mem[bus_addr[7:0]];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } sb_t;
    sb_t         sb_q0[$];
    sb_t         sb_q1[$];
    logic [15:0] last_rdata [2] = '{16'h0, 16'h0};
    int          we_cycles = 0;
    logic [15:0] we_addr = 0, we_din = 0;
    bit          ack_log[$];
    int          ack_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic handle_ack(input bit m);
        sb_t         e;
        logic [15:0] rd;
        rd = m ? m1_rdata : m0_rdata;
        if ((m ? sb_q1.size() : sb_q0.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: m%0d acked with nothing pending (t=%0t)", m, $time);
            return;
        end
        e = m ? sb_q1.pop_front() : sb_q0.pop_front();
        ack_log.push_back(m);
        ack_cyc.push_back(cyc);
        chk("owner", {31'b0, owner}, {31'b0, m});
        if (e.we) begin
            chk("we_cycles", we_cycles, 1);
            chk("we_addr", we_addr, e.addr);
            chk("we_din", we_din, e.wdata);
            chk("rdata_hold", rd, last_rdata[m]);
        end else begin
            chk("we_cycles_rd", we_cycles, 0);
            chk("rdata", rd, e.rdata);
            last_rdata[m] = e.rdata;
        end
        we_cycles = 0;
    endtask

    // Negedge monitor: bus write activity and ack scoreboard
    always @(negedge clk) begin
        if (bus_we) begin
            we_cycles++;
            we_addr = bus_addr;
            we_din  = bus_din;
        end
        if (m0_ack && m1_ack) chk("dual_ack", 2, 1);
        if (m0_ack) handle_ack(1'b0);
        if (m1_ack) handle_ack(1'b1);
    end

    // One transaction; called just after a posedge. Returns just after the
    // posedge following the ack with req dropped (lock left as given).
    task automatic txn(input bit m, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata,
                       input bit lock, input bit check_lat);
        sb_t e;
        int  cnt;
        e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        if (m) begin
            sb_q1.push_back(e);
            m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
        end else begin
            sb_q0.push_back(e);
            m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
        end
        cnt = 0;
        forever begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) break;
            cnt++;
            if (cnt > 40) break;
        end
        if (cnt > 40) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: m%0d addr %h no ack after %0d cycles", m, addr, cnt);
            if (m) void'(sb_q1.pop_back()); else void'(sb_q0.pop_back());
        end else if (check_lat) begin
            chk("latency", cnt, 2);
        end
        @(posedge clk);
        #1;
        if (m) m1_req = 0; else m0_req = 0;
    endtask

    typedef struct {
        bit          m;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;
    vec_t vecs [9];
    bit   exp_order [4];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h0001, 16'h0031, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0031};
        vecs[2] = '{1'b1, 1'b1, 16'h2001, 16'h003C, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'h001A};
        vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[6] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0031};
        vecs[7] = '{1'b0, 1'b1, 16'h00FF, 16'hFFFF, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hFFFF};
`ifdef DBUS_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_din", bus_din, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_owner", owner, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Single transactions from the table, back to back
        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b0, 1'b1);
            if (i == 2) chk("gpio_out", gpio_out, 16'h003C);
        end

        // Both requesters contending for four transactions
        ack_log.delete();
        fork
            begin
                txn(1'b0, 1'b1, 16'h0000, 16'h1110, 16'h0, 1'b0, 1'b0);
                txn(1'b0, 1'b1, 16'h0001, 16'h1111, 16'h0, 1'b0, 1'b0);
            end
            begin
                txn(1'b1, 1'b1, 16'h0002, 16'h2222, 16'h0, 1'b0, 1'b0);
                txn(1'b1, 1'b1, 16'h0003, 16'h2223, 16'h0, 1'b0, 1'b0);
            end
        join
        chk("contend_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size()) chk("contend_order", ack_log[i], exp_order[i]);
        end

        // m1 locks the bus for three writes while m0 waits
        ack_log.delete();
        ack_cyc.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    txn(1'b1, 1'b1, 16'h0020 + 16'(i), 16'h7000 + 16'(i), 16'h0, 1'b1, 1'b0);
                m1_lock = 0;
            end
            begin
                @(posedge clk);
                #1;
                txn(1'b0, 1'b1, 16'h0030, 16'h3030, 16'h0, 1'b0, 1'b0);
            end
        join
        chk("lock_count", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            chk("lock_order", {ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 4'b1110);
            chk("lock_release_gap", ack_cyc[3] - ack_cyc[2], 3);
        end

        // Reset pulsed during ACCESS aborts the transaction
        m0_req = 1; m0_we = 1; m0_addr = 16'h0040; m0_wdata = 16'h4444; m0_lock = 0;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid_bus_we", bus_we, 0);
        chk("rst_mid_acks", {m0_ack, m1_ack}, 0);
        #1;
        rst_n = 1;
        m0_req = 0;
        last_rdata[0] = 16'h0;
        last_rdata[1] = 16'h0;
        we_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", {m0_ack, m1_ack}, 0);
        end
        @(posedge clk);
        #1;
        txn(1'b0, 1'b1, 16'h0040, 16'h5555, 16'h0, 1'b0, 1'b1);
        txn(1'b0, 1'b0, 16'h0040, 16'h0, 16'h5555, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 16'h0021, 16'h0, 16'h7001, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q0.size() + sb_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
